// File: rtl/seg7_scan_driver_if.sv
// Host-side bus for the seven-segment scan driver: digit codes in, pin drive out.
interface seg7_scan_driver_if;
  logic [31:0] iDigits;
  logic [6:0]  oLed;
  logic [7:0]  oEn;
  logic        oTick;

  modport master (output iDigits, input oLed, input oEn, input oTick);
  modport slave  (input iDigits, output oLed, output oEn, output oTick);
endinterface

// File: rtl/seg7_scan_driver.sv
// Eight-digit common-anode seven-segment scan driver: divides the clock to a
// per-digit dwell of TIME cycles and decodes the selected nibble to segments.
module seg7_scan_driver #(
  parameter int unsigned TIME = 200000
) (
  input  logic              iClk,
  input  logic              iRst,
  seg7_scan_driver_if.slave bus
);

  localparam int unsigned     DW       = (TIME > 1) ? $clog2(TIME) : 1;
  localparam logic [DW-1:0]   DIV_LAST = DW'(TIME - 1);

  logic [DW-1:0] div;
  logic [2:0]    idx;
  logic          tick;
  logic [3:0]    code;
  logic [6:0]    led;
  logic [7:0]    en;

  // With TIME = 1 the divider is a constant zero, so tick stays high.
  assign tick = (div == DIV_LAST);

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      div <= '0;
      idx <= '0;
    end else if (tick) begin
      div <= '0;
      idx <= idx + 3'd1;
    end else begin
      div <= div + DW'(1);
    end
  end

  always_comb begin
    code = bus.iDigits[{idx, 2'b00} +: 4];
    en   = ~(8'b0000_0001 << idx);
  end

  always_comb begin
    led = '1;
    case (code)
      4'h0: led = 7'h40;
      4'h1: led = 7'h79;
      4'h2: led = 7'h24;
      4'h3: led = 7'h30;
      4'h4: led = 7'h19;
      4'h5: led = 7'h12;
      4'h6: led = 7'h02;
      4'h7: led = 7'h78;
      4'h8: led = 7'h00;
      4'h9: led = 7'h10;
      4'hA: led = 7'h08;
      4'hB: led = 7'h03;
      4'hC: led = 7'h46;
      4'hD: led = 7'h21;
      4'hE: led = 7'h06;
      4'hF: led = 7'h7F;
      default: led = '1;
    endcase
  end

  assign bus.oLed  = led;
  assign bus.oEn   = en;
  assign bus.oTick = tick;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboarded bench for seg7_scan_driver at TIME=4 and TIME=1, driven by random digit codes and reset pulses.
`timescale 1ns/1ns
module tb_seg7_scan_driver;

  typedef struct packed {
    logic [7:0] en;
    logic [6:0] led;
    logic       tick;
  } obs_t;

  logic clk;
  logic rst;

  seg7_scan_driver_if bus4 ();
  seg7_scan_driver_if bus1 ();

  seg7_scan_driver #(.TIME(4)) dut4 (.iClk(clk), .iRst(rst), .bus(bus4));
  seg7_scan_driver #(.TIME(1)) dut1 (.iClk(clk), .iRst(rst), .bus(bus1));

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h7F};

  obs_t q4[$];
  obs_t q1[$];
  int unsigned checks = 0;
  int unsigned fails  = 0;
  logic [31:0] dig;
  bit done = 0;

  assign bus4.iDigits = dig;
  assign bus1.iDigits = dig;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // n = rising edges since reset release; digit k is lit during edges k*t .. k*t+t-1
  function automatic obs_t model(input int unsigned n, input int unsigned t, input logic [31:0] d);
    obs_t o;
    int unsigned k;
    logic [31:0] sh;
    k = (n / t) % 8;
    for (int unsigned b = 0; b < 8; b++) o.en[b] = (b != k);
    sh = d >> (4 * k);
    o.led  = seg_tab[sh[3:0]];
    o.tick = ((n % t) == t - 1);
    return o;
  endfunction

  // Monitor: outputs are valid every cycle; compare against the oldest expectation.
  initial begin
    obs_t e;
    while (!done) begin
      @(negedge clk);
      if (q4.size() > 0 && q1.size() > 0) begin
        e = q4.pop_front();
        check("en_t4",   {24'h0, bus4.oEn},  {24'h0, e.en});
        check("led_t4",  {25'h0, bus4.oLed}, {25'h0, e.led});
        check("tick_t4", {31'h0, bus4.oTick}, {31'h0, e.tick});
        e = q1.pop_front();
        check("en_t1",   {24'h0, bus1.oEn},  {24'h0, e.en});
        check("led_t1",  {25'h0, bus1.oLed}, {25'h0, e.led});
        check("tick_t1", {31'h0, bus1.oTick}, {31'h0, e.tick});
      end
    end
  end

  initial begin
    int unsigned n;
    bit live_done;
    bit mid_done;
    bit do_rst;
    rst = 0;
    dig = 32'h7654_3210;
    live_done = 0;
    mid_done = 0;
    n = 0;

    // Asynchronous assertion between edges, before any clock edge
    #2 rst = 1;
    #1;
    check("rst_en",    {24'h0, bus4.oEn},   32'h0000_00FE);
    check("rst_led",   {25'h0, bus4.oLed},  32'h0000_0040);
    check("rst_tick4", {31'h0, bus4.oTick}, 32'h0);
    check("rst_tick1", {31'h0, bus1.oTick}, 32'h1);
    check("rst_en1",   {24'h0, bus1.oEn},   32'h0000_00FE);
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    n = 0;

    for (int unsigned c = 0; c < 700; c++) begin
      @(posedge clk);
      #1;
      n++;
      do_rst = 0;
      if (c == 8) begin
        do_rst = 1;
        dig = 32'hFEDC_BA98;
      end else if (c >= 50) begin
        if ($urandom_range(0, 2) == 0) dig = $urandom;
        if (!mid_done && n == 22) begin
          do_rst = 1;
          mid_done = 1;
        end else if ($urandom_range(0, 149) == 0) begin
          do_rst = 1;
        end
      end
      if (do_rst) begin
        rst = 1;
        #1;
        check("midrst_en4", {24'h0, bus4.oEn},  32'h0000_00FE);
        check("midrst_led", {25'h0, bus4.oLed}, {25'h0, seg_tab[dig[3:0]]});
        rst = 0;
        n = 0;
      end
      q4.push_back(model(n, 4, dig));
      q1.push_back(model(n, 1, dig));

      if (!do_rst && !live_done && c >= 60 && ((n / 4) % 8) == 2) begin
        live_done = 1;
        @(negedge clk);
        #1;
        dig[11:8] = 4'h3;
        #1;
        check("live_led3", {25'h0, bus4.oLed}, 32'h0000_0030);
        check("live_en3",  {24'h0, bus4.oEn},  32'h0000_00FB);
        dig[11:8] = 4'hF;
        #1;
        check("live_ledF", {25'h0, bus4.oLed}, 32'h0000_007F);
        check("live_enF",  {24'h0, bus4.oEn},  32'h0000_00FB);
      end
    end

    @(negedge clk);
    @(negedge clk);
    check("queue_drained", q4.size() + q1.size(), 32'h0);
    check("mid_rst_seen",  {31'h0, mid_done},  32'h1);
    check("live_seen",     {31'h0, live_done}, 32'h1);
    done = 1;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
